// File: rtl/fetch_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fetch_stage
// Desc     : Instruction fetch with valid/ready imem port and IF/ID register.
// Revision : 1.0
// ============================================================================

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic [31:0] pc_pend_q, pc_pend_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        kill_q, kill_d;

    logic        req_valid;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;

    logic [31:0] instr_q;
    logic [31:0] pcd_q;
    logic        validd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_next_q    <= RESET_PC;
            pc_pend_q    <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= 32'd0;
            kill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_next_q    <= pc_next_d;
            pc_pend_q    <= pc_pend_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            kill_q       <= kill_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_next_d     = pc_next_q;
        pc_pend_d     = pc_pend_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        kill_d        = kill_q;
        req_valid     = 1'b0;
        deliver       = 1'b0;
        deliver_instr = NOP_INSTR;
        deliver_pc    = 32'd0;

        case (state_q)
            S_REQ: begin
                req_valid = !StallF && !PCSrcE;
                if (req_valid && imem_req_ready) begin
                    pc_pend_d = pc_next_q;
                    pc_next_d = pc_next_q + 32'd4;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q || PCSrcE) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (StallD || FlushD) begin
                        // Decode cannot take it this cycle; park it so it is not lost.
                        hold_instr_d = imem_rsp_data;
                        hold_pc_d    = pc_pend_q;
                        state_d      = S_HOLD;
                    end else begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rsp_data;
                        deliver_pc    = pc_pend_q;
                        req_valid     = !StallF;
                        if (req_valid && imem_req_ready) begin
                            pc_pend_d = pc_next_q;
                            pc_next_d = pc_next_q + 32'd4;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end else if (PCSrcE) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    state_d = S_REQ;
                end else if (!StallD && !FlushD) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_instr_q;
                    deliver_pc    = hold_pc_q;
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (PCSrcE) begin
            pc_next_d = PCTargetE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q  <= NOP_INSTR;
            pcd_q    <= 32'd0;
            validd_q <= 1'b0;
        end else if (FlushD) begin
            instr_q  <= NOP_INSTR;
            pcd_q    <= 32'd0;
            validd_q <= 1'b0;
        end else if (!StallD) begin
            instr_q  <= deliver_instr;
            pcd_q    <= deliver_pc;
            validd_q <= deliver;
        end
    end

    assign imem_req_valid = req_valid && rst_n;
    assign imem_req_addr  = pc_next_q;

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcd_q + 32'd4;
    assign ValidD   = validd_q;
    assign Rs1D     = instr_q[19:15];
    assign Rs2D     = instr_q[24:20];
    assign RdD      = instr_q[11:7];

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fetch_stage
// Desc     : Scoreboard bench for fetch_stage with a behavioural imem model.
// Revision : 1.0
// ============================================================================

module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'd0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [4:0]  Rs1D, Rs2D, RdD;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_pc = 32'd0;
    int          ndeliv = 0;
    bit          saw_wrap = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every fresh decode load must be the next PC of the architectural stream.
    logic        prev_rst = 1'b0, prev_stalld = 1'b0, prev_flushd = 1'b0;
    logic [31:0] mon_e, mon_ei;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && prev_rst && !prev_stalld && !prev_flushd && ValidD) begin
                if (exp_q.size() == 0) begin
                    check("deliver_without_expectation", PCD, 32'hxxxx_xxxx);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_ei = instr_of(mon_e);
                    check("PCD", PCD, mon_e);
                    check("InstrD", InstrD, mon_ei);
                    check("PCPlus4D", PCPlus4D, mon_e + 32'd4);
                    check("Rs1D", {27'd0, Rs1D}, {27'd0, mon_ei[19:15]});
                    check("Rs2D", {27'd0, Rs2D}, {27'd0, mon_ei[24:20]});
                    check("RdD", {27'd0, RdD}, {27'd0, mon_ei[11:7]});
                    exp_q.push_back(mon_e + 32'd4);
                    if (mon_e == 32'd0 && last_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
                    last_pc = mon_e;
                    ndeliv++;
                end
            end
            if (rst_n && !ValidD) begin
                check("bubble_InstrD", InstrD, NOP);
                check("bubble_PCD", PCD, 32'd0);
            end
            if (!rst_n || PCSrcE) check("req_valid_blocked", {31'd0, imem_req_valid}, 32'd0);
            prev_rst    = rst_n;
            prev_stalld = StallD;
            prev_flushd = FlushD;
        end
    end

    // Instruction memory model: one word per accepted request, in order, after lat cycles.
    bit          pend = 1'b0;
    logic [31:0] paddr = 32'd0;
    int          dly = 0;
    int          lat_min = 1, lat_max = 1;
    bit          redir_now;
    logic [31:0] redir_tgt;

    task automatic finish_cycle();
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (imem_rsp_valid) pend = 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                check("one_outstanding", {31'd0, pend}, 32'd0);
                pend  = 1'b1;
                paddr = imem_req_addr;
                dly   = $urandom_range(lat_max, lat_min);
            end
        end
        redir_now = rst_n && PCSrcE;
        redir_tgt = PCTargetE;
        @(posedge clk);
        #1;
        if (redir_now) begin
            exp_q.delete();
            exp_q.push_back(redir_tgt);
        end
        if (pend && dly > 0) dly--;
        imem_rsp_valid = pend && (dly == 0);
        imem_rsp_data  = pend ? instr_of(paddr) : $urandom();
    endtask

    task automatic run_cycle();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic set_ctl(input logic sf, input logic sd, input logic fd, input logic ps,
                           input logic [31:0] tgt);
        StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        run_cycle();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        run_cycle();
        run_cycle();
        rst_n = 1'b1;
    endtask

    logic [31:0] frozen;
    logic [31:0] tmp;
    logic        r_sf, r_sd, r_fd, r_ps;

    initial begin
        // Reset values, first requests, back-to-back throughput
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1;
        do_reset();
        @(negedge clk);
        check("rst_InstrD", InstrD, NOP);
        check("rst_ValidD", {31'd0, ValidD}, 32'd0);
        check("rst_PCD", PCD, 32'd0);
        check("rst_PCPlus4D", PCPlus4D, 32'd4);
        check("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("c1_req_addr", imem_req_addr, 32'h100);
        finish_cycle();
        @(negedge clk);
        check("c2_req_addr", imem_req_addr, 32'h104);
        finish_cycle();
        @(negedge clk);
        check("c3_req_addr", imem_req_addr, 32'h108);
        check("c3_ValidD", {31'd0, ValidD}, 32'd1);
        check("c3_PCD", PCD, 32'h100);
        finish_cycle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stream_ValidD", {31'd0, ValidD}, 32'd1);
            check("stream_PCD", PCD, 32'h104 + 32'(4 * i));
            finish_cycle();
        end

        // Memory not ready right after reset
        imem_req_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nrdy_req_addr", imem_req_addr, 32'h100);
            check("nrdy_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("nrdy_ValidD", {31'd0, ValidD}, 32'd0);
            finish_cycle();
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) run_cycle();

        // StallD as a response arrives: decode frozen, response parked then delivered
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        run_cycle();
        @(negedge clk);
        frozen = last_pc;
        check("stall_PCD", PCD, frozen);
        check("stall_ValidD", {31'd0, ValidD}, 32'd1);
        finish_cycle();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("stall2_PCD", PCD, frozen);
        finish_cycle();
        @(negedge clk);
        check("release_PCD", PCD, frozen + 32'd4);
        check("release_ValidD", {31'd0, ValidD}, 32'd1);
        finish_cycle();

        // Redirect while a slow request is outstanding
        lat_min = 3; lat_max = 3;
        do_reset();
        run_cycle();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        run_cycle();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("kill_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("kill_ValidD", {31'd0, ValidD}, 32'd0);
            finish_cycle();
        end
        @(negedge clk);
        check("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("redir_req_addr", imem_req_addr, 32'h200);
        finish_cycle();
        for (int i = 0; i < 3; i++) run_cycle();
        @(negedge clk);
        check("redir_PCD", PCD, 32'h200);
        check("redir_ValidD", {31'd0, ValidD}, 32'd1);
        finish_cycle();

        // PCSrcE with FlushD while a response is parked
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8; i++) run_cycle();
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        run_cycle();
        set_ctl(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
        run_cycle();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("hold_flush_ValidD", {31'd0, ValidD}, 32'd0);
        check("hold_redir_addr", imem_req_addr, 32'h300);
        check("hold_redir_valid", {31'd0, imem_req_valid}, 32'd1);
        finish_cycle();
        run_cycle();
        @(negedge clk);
        check("hold_redir_PCD", PCD, 32'h300);
        finish_cycle();

        // Address wrap at the top of memory
        for (int i = 0; i < 3; i++) run_cycle();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        run_cycle();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
        finish_cycle();
        @(negedge clk);
        check("wrap_addr1", imem_req_addr, 32'hFFFF_FFFC);
        finish_cycle();
        @(negedge clk);
        check("wrap_addr2", imem_req_addr, 32'h0000_0000);
        finish_cycle();
        @(negedge clk);
        check("wrap_PCPlus4D", PCPlus4D, 32'h0000_0000);
        finish_cycle();
        run_cycle();
        run_cycle();
        check("wrap_seen", {31'd0, saw_wrap}, 32'd1);

        // Randomised traffic with a reset in the middle
        lat_min = 1; lat_max = 3;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset();
            imem_req_ready = (($urandom % 4) != 0);
            r_sf = (($urandom % 6) == 0);
            r_sd = (($urandom % 5) == 0);
            r_ps = (($urandom % 12) == 0);
            r_fd = r_ps || (($urandom % 25) == 0);
            tmp = $urandom();
            if (($urandom % 8) == 0) tmp[31:8] = 24'hFF_FFFF;
            tmp[1:0] = 2'b00;
            set_ctl(r_sf, r_sd, r_fd, r_ps, tmp);
            run_cycle();
        end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        run_cycle();
        check("enough_deliveries", {31'd0, (ndeliv > 200)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
